// File: rtl/bcd_down_counter_if.sv
// Control and data bundle for bcd_down_counter: load/enable/preset in, BCD count and flags out.
interface bcd_down_counter_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic [4*DIGITS-1:0]   q;
  logic                  zero;
  logic                  tc;

  modport master (output en, load, din, input q, zero, tc);
  modport slave  (input en, load, din, output q, zero, tc);
endinterface

// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD down-counter with zero and terminal-count flags.
// Define BCD_DOWN_COUNTER_AUTORELOAD_EN to reload the last preset at terminal count instead of wrapping to all nines.
module bcd_down_counter #(
  parameter int DIGITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  bcd_down_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0]      q_reg;
  logic [W-1:0]      q_next;
  logic [W-1:0]      din_clamped;
  logic [W-1:0]      dec_value;
  logic [DIGITS-1:0] borrow;
  logic              zero;

  assign borrow[0] = 1'b1;

  // Per-digit preset clamp and borrow-ripple decrement; all-zero naturally becomes all nines.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign din_clamped[4*gi +: 4] = (bus.din[4*gi +: 4] > 4'd9) ? 4'd9 : bus.din[4*gi +: 4];
      assign dec_value[4*gi +: 4]   = !borrow[gi]                 ? q_reg[4*gi +: 4] :
                                      (q_reg[4*gi +: 4] == 4'd0)  ? 4'd9 :
                                                                    q_reg[4*gi +: 4] - 4'd1;
      if (gi < DIGITS - 1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] & (q_reg[4*gi +: 4] == 4'd0);
      end
    end
  endgenerate

  assign zero = (q_reg == '0);

`ifdef BCD_DOWN_COUNTER_AUTORELOAD_EN
  logic [W-1:0] reload_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      reload_reg <= '0;
    end else if (bus.load) begin
      reload_reg <= din_clamped;
    end
  end
`endif

  always_comb begin
    q_next = q_reg;
    if (bus.load) begin
      q_next = din_clamped;
    end else if (bus.en) begin
`ifdef BCD_DOWN_COUNTER_AUTORELOAD_EN
      q_next = zero ? reload_reg : dec_value;
`else
      q_next = dec_value;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign bus.q    = q_reg;
  assign bus.zero = zero;
  assign bus.tc   = bus.en & zero & ~bus.load & ~reset;
endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed test of bcd_down_counter (DIGITS=2) against a decimal-arithmetic model checked every cycle.
module tb_bcd_down_counter;
  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  logic clk;
  logic reset;

  bcd_down_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_down_counter #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state as plain decimal integers.
  int  m_val    = 0;
  int  m_reload = 0;
  bit  m_valid  = 1'b0;

  function automatic int from_bcd_clamped(input logic [W-1:0] v);
    int r = 0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      int d = int'(v[4*k +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_val    <= 0;
      m_reload <= 0;
      m_valid  <= 1'b1;
    end else if (bus.load) begin
      m_val    <= from_bcd_clamped(bus.din);
      m_reload <= from_bcd_clamped(bus.din);
    end else if (bus.en) begin
      if (m_val == 0) begin
`ifdef BCD_DOWN_COUNTER_AUTORELOAD_EN
        m_val <= m_reload;
`else
        m_val <= 10**DIGITS - 1;
`endif
      end else begin
        m_val <= m_val - 1;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [W-1:0] eq;
      logic ez, et;
      eq = to_bcd(m_val);
      ez = (m_val == 0);
      et = bus.en & ez & ~bus.load & ~reset;
      checks++;
      if (bus.q !== eq) begin
        errors++;
        $display("FAIL cyc_q: got %h expected %h at %0t", bus.q, eq, $time);
      end
      checks++;
      if (bus.zero !== ez) begin
        errors++;
        $display("FAIL cyc_zero: got %b expected %b at %0t", bus.zero, ez, $time);
      end
      checks++;
      if (bus.tc !== et) begin
        errors++;
        $display("FAIL cyc_tc: got %b expected %b at %0t", bus.tc, et, $time);
      end
    end
  end

  task automatic apply(input logic r, input logic l, input logic e, input logic [W-1:0] d);
    reset    = r;
    bus.load = l;
    bus.en   = e;
    bus.din  = d;
    @(posedge clk);
    #1;
    $display("txn reset=%b load=%b en=%b din=%h -> q=%h zero=%b tc=%b",
             r, l, e, d, bus.q, bus.zero, bus.tc);
  endtask

  task automatic expect_q(input string name, input logic [W-1:0] exp);
    checks++;
    if (bus.q !== exp) begin
      errors++;
      $display("FAIL %s: q got %h expected %h", name, bus.q, exp);
    end
  endtask

  task automatic expect_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.load = 1'b0;
    bus.en   = 1'b0;
    bus.din  = '0;

    apply(1, 0, 0, 8'h00);
    apply(1, 0, 0, 8'h00);
    expect_q("reset_q", 8'h00);
    expect_bit("reset_zero", bus.zero, 1'b1);

    // Count down out of reset.
    apply(0, 0, 1, 8'h00);
`ifdef BCD_DOWN_COUNTER_AUTORELOAD_EN
    expect_q("auto_hold0_a", 8'h00);
    apply(0, 0, 1, 8'h00);
    expect_q("auto_hold0_b", 8'h00);
    expect_bit("auto_hold0_tc", bus.tc, 1'b1);
`else
    expect_q("wrap_99", 8'h99);
    expect_bit("wrap_tc_low", bus.tc, 1'b0);
    apply(0, 0, 1, 8'h00);
    expect_q("wrap_98", 8'h98);
    apply(0, 0, 1, 8'h00);
    expect_q("wrap_97", 8'h97);
`endif

    // Borrow ripple across digits.
    apply(0, 1, 0, 8'h21);
    expect_q("load_21", 8'h21);
    apply(0, 0, 1, 8'h00);
    expect_q("dec_20", 8'h20);
    apply(0, 0, 1, 8'h00);
    expect_q("dec_19", 8'h19);
    apply(0, 0, 1, 8'h00);
    expect_q("dec_18", 8'h18);

    // Preset clamping.
    apply(0, 1, 0, 8'hAF);
    expect_q("clamp_AF", 8'h99);
    apply(0, 1, 0, 8'h5C);
    expect_q("clamp_5C", 8'h59);

    // Terminal count behaviour from a small preset.
    apply(0, 1, 0, 8'h02);
    expect_q("load_02", 8'h02);
    apply(0, 0, 1, 8'h00);
    expect_q("dec_01", 8'h01);
    apply(0, 0, 1, 8'h00);
    expect_q("dec_00", 8'h00);
    expect_bit("tc_at_00", bus.tc, 1'b1);
    apply(0, 0, 1, 8'h00);
`ifdef BCD_DOWN_COUNTER_AUTORELOAD_EN
    expect_q("reload_02", 8'h02);
    apply(0, 0, 1, 8'h00);
    expect_q("reload_01", 8'h01);
`else
    expect_q("wrap2_99", 8'h99);
`endif

    // Simultaneous events: load beats en, reset beats both.
    apply(0, 1, 0, 8'h45);
    expect_q("load_45", 8'h45);
    apply(0, 1, 1, 8'h10);
    expect_q("load_over_en", 8'h10);
    apply(1, 1, 1, 8'h77);
    expect_q("reset_over_all", 8'h00);
    expect_bit("reset_over_zero", bus.zero, 1'b1);

    // Hold with enable low.
    apply(0, 1, 0, 8'h37);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 8'h00);
      expect_q("hold_37", 8'h37);
      expect_bit("hold_tc", bus.tc, 1'b0);
      expect_bit("hold_zero", bus.zero, 1'b0);
    end

    // Long run through several wraps/reloads, checked by the model each cycle.
    apply(0, 1, 0, 8'h13);
    for (int i = 0; i < 40; i++) begin
      apply(0, 0, 1, 8'h00);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
